// File: rtl/mem_pkg.sv
// Shared memory-access types: access size encoding, request record, sizing helper.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'b00,
    MEM_H = 2'b01,
    MEM_W = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } arb_state_e;

  // size is kept as raw bits so the illegal 2'b11 encoding can be carried and flagged
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for a 32-bit word RAM: store byte enables plus replicated write data,
// and load extraction with sign/zero extension. Purely combinational.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_din,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_rdata
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be  = 4'b0000;
    st_din = st_wdata;
    case (st_size)
      MEM_B: begin
        st_be  = 4'b0001 << st_lane;
        st_din = {4{st_wdata[7:0]}};
      end
      MEM_H: begin
        st_be  = 4'b0011 << st_lane;
        st_din = {2{st_wdata[15:0]}};
      end
      MEM_W:   st_be = 4'b1111;
      default: st_be = 4'b0000;
    endcase
  end

  assign ld_shifted = ld_raw >> {ld_lane, 3'b000};

  always_comb begin
    ld_rdata = ld_raw;
    case (ld_size)
      MEM_B: ld_rdata = ld_unsigned ? {24'h0, ld_shifted[7:0]}
                                    : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      MEM_H: ld_rdata = ld_unsigned ? {16'h0, ld_shifted[15:0]}
                                    : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default: ld_rdata = ld_raw;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one BRAM port between two requesters, one transaction in flight.
// Accept in IDLE drives the RAM directly; the response appears READ_LAT cycles later.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int          RAM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          READ_LAT  = 2,
  localparam int         AW        = clogb2(RAM_DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          m0_req_valid_i,
  output logic          m0_req_ready_o,
  input  logic [31:0]   m0_addr_i,
  input  logic          m0_we_i,
  input  logic [1:0]    m0_size_i,
  input  logic          m0_unsigned_i,
  input  logic [31:0]   m0_wdata_i,
  output logic          m0_rsp_valid_o,
  output logic          m0_rsp_err_o,
  output logic [31:0]   m0_rdata_o,
  input  logic          m1_req_valid_i,
  output logic          m1_req_ready_o,
  input  logic [31:0]   m1_addr_i,
  input  logic          m1_we_i,
  input  logic [1:0]    m1_size_i,
  input  logic          m1_unsigned_i,
  input  logic [31:0]   m1_wdata_i,
  output logic          m1_rsp_valid_o,
  output logic          m1_rsp_err_o,
  output logic [31:0]   m1_rdata_o,
  output logic          mem_en_o,
  output logic [3:0]    mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_din_o,
  output logic          mem_regce_o,
  output logic          mem_rst_o,
  input  logic [31:0]   mem_dout_i
);

  localparam logic [32:0] LIMIT = 33'(RAM_DEPTH) * 33'd4;

  arb_state_e  state;
  logic        rr_ptr;
  logic [1:0]  cnt;
  logic        l_gid, l_we, l_err, l_unsigned;
  logic [1:0]  l_lane, l_size;

  mem_req_t    req0, req1, req_sel;
  logic        idle, gnt1, accept, err_now, issue, resp, load_ok;
  logic [31:0] off;
  logic [1:0]  lane;
  logic [3:0]  st_be;
  logic [31:0] st_din, ld_rdata;

  assign req0 = '{addr: m0_addr_i, we: m0_we_i, size: m0_size_i,
                  is_unsigned: m0_unsigned_i, wdata: m0_wdata_i};
  assign req1 = '{addr: m1_addr_i, we: m1_we_i, size: m1_size_i,
                  is_unsigned: m1_unsigned_i, wdata: m1_wdata_i};

  // rr_ptr == 1 favours m1 when both request in the same cycle
  assign idle    = (state == S_IDLE);
  assign gnt1    = m1_req_valid_i & (~m0_req_valid_i | rr_ptr);
  assign accept  = idle & (m0_req_valid_i | m1_req_valid_i);
  assign req_sel = gnt1 ? req1 : req0;

  assign m0_req_ready_o = idle & m0_req_valid_i & ~gnt1;
  assign m1_req_ready_o = idle & gnt1;

  assign off  = req_sel.addr - BASE_ADDR;
  assign lane = off[1:0];

  always_comb begin
    err_now = 1'b0;
    if (req_sel.size == 2'b11)                      err_now = 1'b1;
    if (req_sel.size == MEM_H && lane[0])           err_now = 1'b1;
    if (req_sel.size == MEM_W && lane != 2'b00)     err_now = 1'b1;
    if (req_sel.addr < BASE_ADDR)                   err_now = 1'b1;
    if ({1'b0, off} >= LIMIT)                       err_now = 1'b1;
  end

  mem_lane_align u_align (
    .st_size     (req_sel.size),
    .st_lane     (lane),
    .st_wdata    (req_sel.wdata),
    .st_be       (st_be),
    .st_din      (st_din),
    .ld_size     (l_size),
    .ld_lane     (l_lane),
    .ld_unsigned (l_unsigned),
    .ld_raw      (mem_dout_i),
    .ld_rdata    (ld_rdata)
  );

  assign issue       = accept & ~err_now;
  assign mem_en_o    = issue;
  assign mem_addr_o  = issue ? off[AW+1:2] : '0;
  assign mem_we_o    = (issue & req_sel.we) ? st_be : 4'b0000;
  assign mem_din_o   = (issue & req_sel.we) ? st_din : 32'h0;
  assign mem_regce_o = (state == S_WAIT) & ~l_we & ~l_err;
  assign mem_rst_o   = 1'b0;

  assign resp    = (state == S_RESP);
  assign load_ok = ~l_we & ~l_err;

  assign m0_rsp_valid_o = resp & ~l_gid;
  assign m1_rsp_valid_o = resp & l_gid;
  assign m0_rsp_err_o   = resp & ~l_gid & l_err;
  assign m1_rsp_err_o   = resp & l_gid & l_err;
  assign m0_rdata_o     = (resp & ~l_gid & load_ok) ? ld_rdata : 32'h0;
  assign m1_rdata_o     = (resp & l_gid & load_ok) ? ld_rdata : 32'h0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      rr_ptr     <= 1'b0;
      cnt        <= 2'd0;
      l_gid      <= 1'b0;
      l_we       <= 1'b0;
      l_err      <= 1'b0;
      l_unsigned <= 1'b0;
      l_lane     <= 2'd0;
      l_size     <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rr_ptr     <= ~gnt1;
            l_gid      <= gnt1;
            l_we       <= req_sel.we;
            l_err      <= err_now;
            l_unsigned <= req_sel.is_unsigned;
            l_lane     <= lane;
            l_size     <= req_sel.size;
            // with no RAM output register the data is ready one cycle after accept
            if (READ_LAT <= 1) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= (READ_LAT > 2) ? 2'(READ_LAT - 2) : 2'd0;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 2'd0) state <= S_RESP;
          else             cnt   <= cnt - 2'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a READ_LAT=2/base 0 instance and a READ_LAT=1/base 0x1000 instance,
// each with its own behavioural RAM, checked against a byte-level shadow memory model.
module tb_mem_port_arbiter;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        vld   [2][2];
  logic        we    [2][2];
  logic        uns   [2][2];
  logic [1:0]  size  [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        rdy   [2][2];
  logic        rvld  [2][2];
  logic        rerr  [2][2];
  logic [31:0] rdata [2][2];
  logic        mem_en[2], regce[2], mrst[2];
  logic [3:0]  mwe   [2];
  logic [9:0]  maddr [2];
  logic [31:0] din   [2], dout[2];

  logic [31:0] ram [2][DEPTH];
  logic [31:0] q1;
  logic        ram_clr;

  logic [7:0]  sh [2][4*DEPTH];
  logic        rr [2];
  int          vectors = 0, miscompares = 0;

  mem_port_arbiter #(.RAM_DEPTH(DEPTH), .BASE_ADDR(32'h0), .READ_LAT(2)) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .m0_req_valid_i(vld[0][0]), .m0_req_ready_o(rdy[0][0]), .m0_addr_i(addr[0][0]),
    .m0_we_i(we[0][0]), .m0_size_i(size[0][0]), .m0_unsigned_i(uns[0][0]),
    .m0_wdata_i(wdata[0][0]), .m0_rsp_valid_o(rvld[0][0]), .m0_rsp_err_o(rerr[0][0]),
    .m0_rdata_o(rdata[0][0]),
    .m1_req_valid_i(vld[0][1]), .m1_req_ready_o(rdy[0][1]), .m1_addr_i(addr[0][1]),
    .m1_we_i(we[0][1]), .m1_size_i(size[0][1]), .m1_unsigned_i(uns[0][1]),
    .m1_wdata_i(wdata[0][1]), .m1_rsp_valid_o(rvld[0][1]), .m1_rsp_err_o(rerr[0][1]),
    .m1_rdata_o(rdata[0][1]),
    .mem_en_o(mem_en[0]), .mem_we_o(mwe[0]), .mem_addr_o(maddr[0]), .mem_din_o(din[0]),
    .mem_regce_o(regce[0]), .mem_rst_o(mrst[0]), .mem_dout_i(dout[0])
  );

  mem_port_arbiter #(.RAM_DEPTH(DEPTH), .BASE_ADDR(32'h1000), .READ_LAT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .m0_req_valid_i(vld[1][0]), .m0_req_ready_o(rdy[1][0]), .m0_addr_i(addr[1][0]),
    .m0_we_i(we[1][0]), .m0_size_i(size[1][0]), .m0_unsigned_i(uns[1][0]),
    .m0_wdata_i(wdata[1][0]), .m0_rsp_valid_o(rvld[1][0]), .m0_rsp_err_o(rerr[1][0]),
    .m0_rdata_o(rdata[1][0]),
    .m1_req_valid_i(vld[1][1]), .m1_req_ready_o(rdy[1][1]), .m1_addr_i(addr[1][1]),
    .m1_we_i(we[1][1]), .m1_size_i(size[1][1]), .m1_unsigned_i(uns[1][1]),
    .m1_wdata_i(wdata[1][1]), .m1_rsp_valid_o(rvld[1][1]), .m1_rsp_err_o(rerr[1][1]),
    .m1_rdata_o(rdata[1][1]),
    .mem_en_o(mem_en[1]), .mem_we_o(mwe[1]), .mem_addr_o(maddr[1]), .mem_din_o(din[1]),
    .mem_regce_o(regce[1]), .mem_rst_o(mrst[1]), .mem_dout_i(dout[1])
  );

  // RAM 0 has an output register (enabled by regce); RAM 1 is read straight into dout
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int w = 0; w < DEPTH; w++) begin
        ram[0][w] <= 32'h0;
        ram[1][w] <= 32'h0;
      end
    end else begin
      if (mem_en[0]) begin
        for (int b = 0; b < 4; b++)
          if (mwe[0][b]) ram[0][maddr[0]][8*b +: 8] <= din[0][8*b +: 8];
        if (mwe[0] == 4'b0000) q1 <= ram[0][maddr[0]];
      end
      if (regce[0]) dout[0] <= q1;
      if (mem_en[1]) begin
        for (int b = 0; b < 4; b++)
          if (mwe[1][b]) ram[1][maddr[1]][8*b +: 8] <= din[1][8*b +: 8];
        if (mwe[1] == 4'b0000) dout[1] <= ram[1][maddr[1]];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference: expected response and RAM-side signals from plain byte arithmetic
  function automatic void model(input int d, input logic [31:0] a, input logic w,
                                input logic [1:0] sz, input logic u, input logic [31:0] wd,
                                output logic e, output logic [31:0] rd, output logic [3:0] be,
                                output logic [31:0] dn, output logic [31:0] word);
    longint base, off, v;
    int n;
    base = (d == 0) ? 64'h0 : 64'h1000;
    off  = longint'(a) - base;
    n    = 1 << sz;
    e    = (sz == 2'b11) || (off < 0) || (off >= 4*DEPTH) || ((off % n) != 0);
    rd = 0; be = 0; dn = 0; word = 0;
    if (!e) begin
      word = 32'(off / 4);
      be   = 4'(((1 << n) - 1) << int'(off % 4));
      for (int i = 0; i < 4; i++) dn[8*i +: 8] = wd[8*(i % n) +: 8];
      if (!w) begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(sh[d][int'(off) + i]) << (8*i));
        if (!u && n < 4 && v >= (64'sd1 << (8*n - 1))) v = v - (64'sd1 << (8*n));
        rd = 32'(v);
      end
    end
  endfunction

  task automatic txn(input int d, input int p, input logic [31:0] a, input logic w,
                     input logic [1:0] sz, input logic u, input logic [31:0] wd,
                     output logic got_err, output logic [31:0] got_rd);
    logic e; logic [31:0] rd, dn, wordx; logic [3:0] be;
    int lat, k, q;
    model(d, a, w, sz, u, wd, e, rd, be, dn, wordx);
    lat = (d == 0) ? 2 : 1;
    q   = 1 - p;
    got_err = 1'bx; got_rd = 'x;
    @(negedge clk);
    vld[d][p] = 1; addr[d][p] = a; we[d][p] = w; size[d][p] = sz; uns[d][p] = u; wdata[d][p] = wd;
    #1;
    k = 0;
    while (!rdy[d][p] && k < 8) begin @(negedge clk); #1; k++; end
    chk("req_ready", rdy[d][p], 1);
    if (!rdy[d][p]) begin vld[d][p] = 0; return; end
    chk("mem_en_accept", mem_en[d], !e);
    chk("mem_we", mwe[d], w ? be : 4'b0000);
    if (!e) chk("mem_addr", maddr[d], wordx);
    if (!e && w) chk("mem_din", din[d], dn);
    @(posedge clk); #1;
    vld[d][p] = 0;
    rr[d] = q[0];
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        chk("mem_en_wait", mem_en[d], 0);
        if (!e) chk("regce_wait", regce[d], !w);
        chk("rsp_err_idle", rerr[d][p], 0);
      end
      chk("rsp_valid_own", rvld[d][p], c == lat);
      chk("rsp_valid_other", rvld[d][q], 0);
      chk("rsp_err_other", rerr[d][q], 0);
      if (c == lat) begin
        got_err = rerr[d][p];
        got_rd  = rdata[d][p];
        chk("rsp_err", got_err, e);
        chk("rsp_rdata", got_rd, rd);
      end
    end
    @(negedge clk);
    chk("rsp_pulse_end", rvld[d][p], 0);
    if (w && !e)
      for (int i = 0; i < 4; i++)
        if (be[i]) sh[d][4*int'(wordx) + i] = dn[8*i +: 8];
  endtask

  // Hold one load valid: ready must open once every READ_LAT+1 cycles
  task automatic burst(input int d);
    int lat;
    lat = (d == 0) ? 2 : 1;
    @(negedge clk);
    vld[d][0] = 1; addr[d][0] = (d == 0) ? 32'h10 : 32'h1010; we[d][0] = 0;
    size[d][0] = 2'b10; uns[d][0] = 0;
    for (int i = 0; i < 2*(lat+1); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("burst_ready", rdy[d][0], (i % (lat+1)) == 0);
      chk("burst_rsp", rvld[d][0], (i % (lat+1)) == lat);
    end
    @(negedge clk);
    vld[d][0] = 0;
    rr[d] = 1'b1;
  endtask

  typedef struct {
    int d; int p; logic [31:0] a; logic w; logic [1:0] sz; logic u; logic [31:0] wd;
    logic e; logic [31:0] rd;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic ge; logic [31:0] grd;
    int rem[2];
    logic e0; logic [31:0] rd0, dn0, wd0; logic [3:0] be0;

    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 0; rr[d] = 0;
      for (int p = 0; p < 2; p++) begin
        vld[d][p] = 0; we[d][p] = 0; uns[d][p] = 0; size[d][p] = 0;
        addr[d][p] = 0; wdata[d][p] = 0;
      end
      for (int i = 0; i < 4*DEPTH; i++) sh[d][i] = 8'h0;
    end
    ram_clr = 1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        chk("reset_ready", rdy[d][p], 0);
        chk("reset_rsp_valid", rvld[d][p], 0);
        chk("reset_rsp_err", rerr[d][p], 0);
        chk("reset_rdata", rdata[d][p], 0);
      end
      chk("reset_mem_en", mem_en[d], 0);
      chk("reset_mem_we", mwe[d], 0);
      chk("reset_mem_addr", maddr[d], 0);
      chk("reset_mem_din", din[d], 0);
      chk("reset_regce", regce[d], 0);
      chk("reset_mem_rst", mrst[d], 0);
    end
    ram_clr = 0;
    rst_n[0] = 1; rst_n[1] = 1;

    // Both requesters pending: grants must alternate starting from m0
    addr[0][0] = 32'h10; addr[0][1] = 32'h14;
    for (int p = 0; p < 2; p++) begin we[0][p] = 0; size[0][p] = 2'b10; uns[0][p] = 0; end
    rem[0] = 3; rem[1] = 3;
    for (int r = 0; r < 6; r++) begin
      int g;
      @(negedge clk);
      vld[0][0] = rem[0] > 0; vld[0][1] = rem[1] > 0;
      #1;
      g = (vld[0][0] && vld[0][1]) ? int'(rr[0]) : (vld[0][0] ? 0 : 1);
      chk("arb_ready_m0", rdy[0][0], g == 0);
      chk("arb_ready_m1", rdy[0][1], g == 1);
      model(0, addr[0][g], 0, 2'b10, 0, 0, e0, rd0, be0, dn0, wd0);
      @(posedge clk); #1;
      vld[0][g] = 0; rem[g]--; rr[0] = (g == 0);
      for (int c = 1; c <= 2; c++) begin
        @(negedge clk);
        chk("arb_rsp_own", rvld[0][g], c == 2);
        chk("arb_rsp_other", rvld[0][1-g], 0);
        if (c == 2) chk("arb_rdata", rdata[0][g], rd0);
      end
    end
    @(negedge clk);
    vld[0][0] = 0; vld[0][1] = 0;

    tbl.push_back('{0, 0, 32'h10,  1, 2'd2, 0, 32'hDEADBEEF, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h10,  0, 2'd2, 0, 32'h0,        0, 32'hDEADBEEF});
    tbl.push_back('{0, 0, 32'h13,  1, 2'd0, 0, 32'h000000A5, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h13,  0, 2'd0, 0, 32'h0,        0, 32'hFFFFFFA5});
    tbl.push_back('{0, 0, 32'h13,  0, 2'd0, 1, 32'h0,        0, 32'h000000A5});
    tbl.push_back('{0, 0, 32'h12,  0, 2'd0, 0, 32'h0,        0, 32'hFFFFFFAD});
    tbl.push_back('{0, 1, 32'h12,  0, 2'd1, 1, 32'h0,        0, 32'h0000A5AD});
    tbl.push_back('{0, 1, 32'h10,  0, 2'd2, 0, 32'h0,        0, 32'hA5ADBEEF});
    tbl.push_back('{0, 1, 32'h21,  0, 2'd1, 0, 32'h0,        1, 32'h0});
    tbl.push_back('{0, 1, 32'h1000,0, 2'd2, 0, 32'h0,        1, 32'h0});
    tbl.push_back('{0, 1, 32'h22,  1, 2'd1, 0, 32'h12348001, 0, 32'h0});
    tbl.push_back('{0, 0, 32'h22,  0, 2'd1, 0, 32'h0,        0, 32'hFFFF8001});
    tbl.push_back('{0, 0, 32'h22,  0, 2'd1, 1, 32'h0,        0, 32'h00008001});
    tbl.push_back('{0, 0, 32'h10,  0, 2'd3, 0, 32'h0,        1, 32'h0});
    tbl.push_back('{0, 0, 32'h12,  1, 2'd2, 0, 32'h55555555, 1, 32'h0});
    tbl.push_back('{0, 1, 32'hFFC, 1, 2'd2, 0, 32'h11223344, 0, 32'h0});
    tbl.push_back('{0, 1, 32'hFFC, 0, 2'd2, 0, 32'h0,        0, 32'h11223344});
    tbl.push_back('{0, 0, 32'hFFF, 0, 2'd0, 1, 32'h0,        0, 32'h00000011});
    tbl.push_back('{1, 0, 32'h1010,1, 2'd2, 0, 32'hCAFEF00D, 0, 32'h0});
    tbl.push_back('{1, 0, 32'h1010,0, 2'd2, 0, 32'h0,        0, 32'hCAFEF00D});
    tbl.push_back('{1, 0, 32'h0FFC,0, 2'd2, 0, 32'h0,        1, 32'h0});
    tbl.push_back('{1, 1, 32'h1011,0, 2'd0, 1, 32'h0,        0, 32'h000000F0});
    tbl.push_back('{1, 1, 32'h1011,0, 2'd0, 0, 32'h0,        0, 32'hFFFFFFF0});
    tbl.push_back('{1, 0, 32'h2000,0, 2'd2, 0, 32'h0,        1, 32'h0});
    tbl.push_back('{1, 1, 32'h1012,0, 2'd1, 0, 32'h0,        0, 32'hFFFFCAFE});
    for (int i = 0; i < tbl.size(); i++) begin
      txn(tbl[i].d, tbl[i].p, tbl[i].a, tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].wd, ge, grd);
      chk("tbl_err", ge, tbl[i].e);
      chk("tbl_rdata", grd, tbl[i].rd);
    end

    burst(0);
    burst(1);

    // Reset while the load waits on the RAM: no response, rr_ptr back to m0
    @(negedge clk);
    vld[0][0] = 1; addr[0][0] = 32'h10; we[0][0] = 0; size[0][0] = 2'b10;
    @(posedge clk); #1;
    vld[0][0] = 0;
    @(negedge clk);
    rst_n[0] = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("rst_rsp_m0", rvld[0][0], 0);
      chk("rst_rsp_m1", rvld[0][1], 0);
      chk("rst_mem_en", mem_en[0], 0);
      @(negedge clk);
    end
    rst_n[0] = 1; rr[0] = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_rsp", rvld[0][0] | rvld[0][1], 0);
    end
    vld[0][0] = 1; vld[0][1] = 1; addr[0][1] = 32'h14; we[0][1] = 0; size[0][1] = 2'b10;
    #1;
    chk("post_rst_ready_m0", rdy[0][0], 1);
    chk("post_rst_ready_m1", rdy[0][1], 0);
    #1;
    vld[0][0] = 0; vld[0][1] = 0;

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      int d;
      d = (i % 5 == 4) ? 1 : 0;
      case ($urandom_range(0, 7))
        0: a = (d == 0) ? $urandom : 32'h0FF0 + $urandom_range(0, 31);
        1: a = (d == 0) ? 32'h0FF0 + $urandom_range(0, 31) : 32'h1FF0 + $urandom_range(0, 31);
        default: a = ((d == 0) ? 32'h0 : 32'h1000) + $urandom_range(0, 127);
      endcase
      txn(d, $urandom_range(0, 1), a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), $urandom, ge, grd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
